// File: rtl/neural_soc_isig_read_arbiter_if.sv
// Requester-side and Avalon-MM PIO read signals shared by the input-signal read arbiter
// and its environment.
interface neural_soc_isig_read_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]   req;
   logic [2*NUM_REQ-1:0] req_addr;
   logic [NUM_REQ-1:0]   gnt;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [DATA_W-1:0]    rsp_data;
   logic [1:0]           avm_address;
   logic                 avm_read;
   logic [DATA_W-1:0]    avm_readdata;

   // master is the arbiter itself: Avalon master toward the PIO, grant source toward requesters
   modport master (
      input  req, req_addr, avm_readdata,
      output gnt, rsp_valid, rsp_data, avm_address, avm_read
   );

   modport slave (
      output req, req_addr, avm_readdata,
      input  gnt, rsp_valid, rsp_data, avm_address, avm_read
   );
endinterface

// File: rtl/neural_soc_isig_read_arbiter.sv
// Round-robin arbiter sharing one fixed-latency Avalon-MM PIO read slave between NUM_REQ
// requesters; one read in flight, response routed back to the granted requester.
module neural_soc_isig_read_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int READ_LATENCY = 1,
   parameter int DATA_W       = 32
) (
   input logic                           clk,
   input logic                           reset,
   neural_soc_isig_read_arbiter_if.master bus
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(READ_LATENCY + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   generate
      if (READ_LATENCY < 1) begin : g_bad_latency
         $error("READ_LATENCY must be at least 1");
      end
      if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
         $error("NUM_REQ must be in 2..8");
      end
   endgenerate

   logic [1:0]       state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] win_q;
   logic [CNT_W-1:0] cnt;

   logic             win_found;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] cand_idx;
   logic [1:0]       win_addr;
   int               cand;

   // First requesting index at or above rr_ptr, wrapping past NUM_REQ-1 back to 0.
   // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = PTR_W'(cand);
         if (!win_found && bus.req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   assign win_addr = bus.req_addr[{win_idx, 1'b0} +: 2];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_IDLE;
         rr_ptr          <= '0;
         win_q           <= '0;
         cnt             <= '0;
         bus.gnt         <= '0;
         bus.rsp_valid   <= '0;
         bus.rsp_data    <= '0;
         bus.avm_read    <= 1'b0;
         bus.avm_address <= 2'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  win_q           <= win_idx;
                  bus.gnt         <= NUM_REQ'(1) << win_idx;
                  bus.avm_read    <= 1'b1;
                  bus.avm_address <= win_addr;
                  state           <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               bus.gnt         <= '0;
               bus.avm_read    <= 1'b0;
               bus.avm_address <= 2'd0;
               rr_ptr          <= (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
               cnt             <= CNT_W'(READ_LATENCY);
               state           <= S_WAIT;
            end
            S_WAIT: begin
               // Slave data is valid exactly READ_LATENCY cycles after the read strobe.
               if (cnt == CNT_W'(1)) begin
                  bus.rsp_data  <= bus.avm_readdata;
                  bus.rsp_valid <= NUM_REQ'(1) << win_q;
                  cnt           <= '0;
                  state         <= S_RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RESP: begin
               bus.rsp_valid <= '0;
               state         <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_neural_soc_isig_read_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants/responses, a negedge monitor pops and compares.
module tb_neural_soc_isig_read_arbiter;
   localparam int NR = 4;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   neural_soc_isig_read_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) if1 ();
   neural_soc_isig_read_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) if3 ();

   neural_soc_isig_read_arbiter #(.NUM_REQ(NR), .READ_LATENCY(1), .DATA_W(DW)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   neural_soc_isig_read_arbiter #(.NUM_REQ(NR), .READ_LATENCY(3), .DATA_W(DW)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (if3)
   );

   typedef struct {
      int         idx;
      logic [1:0] addr;
      int         cyc;
   } g_exp_t;

   typedef struct {
      int          idx;
      logic [31:0] data;
      int          cyc;
   } r_exp_t;

   g_exp_t gq[2][$];
   r_exp_t rq[2][$];

   function automatic logic [31:0] slv(input logic [1:0] a);
      case (a)
         2'd0:    return 32'hDEAD_BEEF;
         2'd1:    return 32'h1111_0001;
         2'd2:    return 32'h2222_0002;
         default: return 32'h3333_0003;
      endcase
   endfunction

   // Registered PIO slave with one cycle of read latency; garbage when not being read.
   always @(posedge clk) begin
      if (if1.avm_read) if1.avm_readdata <= slv(if1.avm_address);
      else              if1.avm_readdata <= 32'h0BAD_0BAD;
   end

   // The latency-3 slave shows a different word every cycle so only the right one can be captured.
   initial begin
      if3.avm_readdata = 32'h0;
      forever begin
         @(negedge clk);
         if3.avm_readdata = 32'hC0DE_0000 + cyc;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon(input int u, input logic [3:0] g, input logic [3:0] rv,
                      input logic [31:0] rd, input logic rs, input logic [1:0] ad);
      g_exp_t ge;
      r_exp_t re;
      if (g != 4'b0) begin
         if (gq[u].size() == 0) begin
            check($sformatf("u%0d_gnt_unexpected", u), 64'(g), 64'(0));
         end else begin
            ge = gq[u].pop_front();
            check($sformatf("u%0d_gnt", u), 64'(g), 64'(4'b0001 << ge.idx));
            check($sformatf("u%0d_gnt_cycle", u), 64'(cyc), 64'(ge.cyc));
            check($sformatf("u%0d_avm_read", u), 64'(rs), 64'(1));
            check($sformatf("u%0d_avm_address", u), 64'(ad), 64'(ge.addr));
         end
      end else if (rs) begin
         check($sformatf("u%0d_avm_read_without_gnt", u), 64'(rs), 64'(0));
      end
      if (rv != 4'b0) begin
         check($sformatf("u%0d_gnt_rsp_overlap", u), 64'(g), 64'(0));
         if (rq[u].size() == 0) begin
            check($sformatf("u%0d_rsp_unexpected", u), 64'(rv), 64'(0));
         end else begin
            re = rq[u].pop_front();
            check($sformatf("u%0d_rsp_valid", u), 64'(rv), 64'(4'b0001 << re.idx));
            check($sformatf("u%0d_rsp_cycle", u), 64'(cyc), 64'(re.cyc));
            check($sformatf("u%0d_rsp_data", u), 64'(rd), 64'(re.data));
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, if1.gnt, if1.rsp_valid, if1.rsp_data, if1.avm_read, if1.avm_address);
      mon(1, if3.gnt, if3.rsp_valid, if3.rsp_data, if3.avm_read, if3.avm_address);
   end

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         if (gq[0].size() == 0 && rq[0].size() == 0 && gq[1].size() == 0 && rq[1].size() == 0) break;
         @(negedge clk);
      end
      @(negedge clk);
      check("drain_timeout", 64'(gq[0].size() + rq[0].size() + gq[1].size() + rq[1].size()), 64'(0));
      gq[0].delete(); rq[0].delete(); gq[1].delete(); rq[1].delete();
   endtask

   // Hold req for n transactions on the latency-1 unit; order[] gives the expected winners.
   task automatic run(input logic [3:0] r, input logic [7:0] addr, input int n, input int order[8]);
      int c;
      @(negedge clk);
      c = cyc;
      if1.req      = r;
      if1.req_addr = addr;
      for (int k = 0; k < n; k++) begin
         gq[0].push_back('{idx: order[k], addr: addr[2*order[k] +: 2], cyc: c + 1 + 4*k});
         rq[0].push_back('{idx: order[k], data: slv(addr[2*order[k] +: 2]), cyc: c + 3 + 4*k});
      end
      repeat (4*(n-1) + 1) @(negedge clk);
      if1.req = 4'b0;
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int c;
      reset        = 1'b1;
      if1.req      = 4'b1111;
      if1.req_addr = 8'hE4;
      if3.req      = 4'b0;
      if3.req_addr = 8'h00;

      // 1. Reset held with all requests high: everything stays quiet.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_gnt", 64'(if1.gnt), 64'(0));
         check("reset_rsp_valid", 64'(if1.rsp_valid), 64'(0));
         check("reset_rsp_data", 64'(if1.rsp_data), 64'(0));
         check("reset_avm_read", 64'(if1.avm_read), 64'(0));
         check("reset_avm_address", 64'(if1.avm_address), 64'(0));
      end
      check("reset_u3_rsp_data", 64'(if3.rsp_data), 64'(0));
      if1.req = 4'b0;
      reset   = 1'b0;

      // 2. Single read from requester 2 at address 0.
      run(4'b0100, 8'b11_00_01_00, 1, '{2, 0, 0, 0, 0, 0, 0, 0});

      // 3. Round-robin from a fresh pointer with all requests held.
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      run(4'b1111, 8'hE4, 8, '{0, 1, 2, 3, 0, 1, 2, 3});

      // 4. Wrap and skip.
      run(4'b0100, 8'hE4, 1, '{2, 0, 0, 0, 0, 0, 0, 0});
      run(4'b0011, 8'hE4, 2, '{0, 1, 0, 0, 0, 0, 0, 0});
      run(4'b1000, 8'hE4, 1, '{3, 0, 0, 0, 0, 0, 0, 0});
      run(4'b1001, 8'hE4, 2, '{0, 3, 0, 0, 0, 0, 0, 0});

      // 5. Reset during WAIT abandons the read; pointer restarts at 0.
      run(4'b0001, 8'hE4, 1, '{0, 0, 0, 0, 0, 0, 0, 0});
      @(negedge clk);
      c = cyc;
      if1.req      = 4'b0010;
      if1.req_addr = 8'hE4;
      gq[0].push_back('{idx: 1, addr: 2'd1, cyc: c + 1});
      @(negedge clk);
      if1.req = 4'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midop_reset_rsp_data", 64'(if1.rsp_data), 64'(0));
      repeat (5) @(negedge clk);
      run(4'b1111, 8'hE4, 1, '{0, 0, 0, 0, 0, 0, 0, 0});

      // 6. READ_LATENCY=3: capture exactly the word present in cycle 4.
      @(negedge clk);
      c = cyc;
      if3.req      = 4'b0001;
      if3.req_addr = 8'h00;
      gq[1].push_back('{idx: 0, addr: 2'd0, cyc: c + 1});
      rq[1].push_back('{idx: 0, data: 32'hC0DE_0000 + (c + 4), cyc: c + 5});
      @(negedge clk);
      if3.req = 4'b0;
      drain();
      repeat (3) @(negedge clk);
      check("u3_rsp_data_retained", 64'(if3.rsp_data), 64'(32'hC0DE_0000 + (c + 4)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
